// File: rtl/sabouter_injection_ctrl.sv
// Fault-injection step controller feeding the super saboteur: latches one
// configuration, waits for a trigger plus delay, then drives the enables for the programmed window.
module sabouter_injection_ctrl #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 16,
  parameter int ICNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [WIDTH-1:0]  i_cfg_mask,
  input  logic [1:0]        i_cfg_ctrl,
  input  logic [CNT_W-1:0]  i_cfg_delay,
  input  logic [CNT_W-1:0]  i_cfg_duration,
  input  logic              i_trigger,
  input  logic              i_abort,
  output logic              o_en_super_sabouter,
  output logic [WIDTH-1:0]  o_en_basic_sabouter,
  output logic [1:0]        o_ctrl,
  output logic              o_busy,
  output logic              o_done,
  output logic [ICNT_W-1:0] o_inject_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_INJECT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ICNT_W-1:0] ICNT_ONE = {{(ICNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [WIDTH-1:0]  mask_r;
  logic [CNT_W-1:0]  dur_r;
  logic [CNT_W-1:0]  dly_cnt_r;
  logic [CNT_W-1:0]  dur_cnt_r;
  logic              accept_s;
  logic              complete_s;
  logic              inject_hold_s;

  // Next-state decode; abort has priority over trigger and over completion.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          accept_s = 1'b1;
          state_s  = ST_ARMED;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (i_abort) begin
          state_s = ST_IDLE;
        end else if (i_trigger) begin
          state_s = (dly_cnt_r == CNT_ZERO) ? ST_INJECT : ST_WAIT;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_WAIT: begin
        if (i_abort) begin
          state_s = ST_IDLE;
        end else if (dly_cnt_r <= CNT_ONE) begin
          state_s = ST_INJECT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_INJECT: begin
        if (i_abort) begin
          state_s = ST_IDLE;
        end else if ((dur_cnt_r == CNT_ZERO) && (dur_r != CNT_ZERO)) begin
          complete_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s    = ST_INJECT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Enables lag entry into INJECT by one edge so the first enabled cycle
  // lands exactly delay+1 edges after the trigger edge.
  assign inject_hold_s = (state_r == ST_INJECT) && (state_s == ST_INJECT);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Configuration latch plus delay/duration down-counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_r    <= {WIDTH{1'b0}};
      o_ctrl    <= 2'b00;
      dur_r     <= CNT_ZERO;
      dly_cnt_r <= CNT_ZERO;
      dur_cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      mask_r    <= i_cfg_mask;
      o_ctrl    <= i_cfg_ctrl;
      dur_r     <= i_cfg_duration;
      dly_cnt_r <= i_cfg_delay;
      dur_cnt_r <= i_cfg_duration;
    end else begin
      if ((state_r == ST_WAIT) && (dly_cnt_r != CNT_ZERO)) begin
        dly_cnt_r <= dly_cnt_r - CNT_ONE;
      end
      if ((state_r == ST_INJECT) && (dur_cnt_r != CNT_ZERO)) begin
        dur_cnt_r <= dur_cnt_r - CNT_ONE;
      end
    end
  end

  // Registered status and enable outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cfg_ready         <= 1'b1;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_en_super_sabouter <= 1'b0;
      o_en_basic_sabouter <= {WIDTH{1'b0}};
      o_inject_cnt        <= {ICNT_W{1'b0}};
    end else begin
      o_cfg_ready         <= (state_s == ST_IDLE);
      o_busy              <= (state_s != ST_IDLE);
      o_done              <= complete_s;
      o_en_super_sabouter <= inject_hold_s;
      o_en_basic_sabouter <= inject_hold_s ? mask_r : {WIDTH{1'b0}};
      if (complete_s && !(&o_inject_cnt)) begin
        o_inject_cnt <= o_inject_cnt + ICNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sabouter_injection_ctrl.sv
// Bench for sabouter_injection_ctrl: table of injection steps with a per-cycle
// expectation queue, plus reset, saturation and async-reset sequences.
module tb_sabouter_injection_ctrl;
  localparam int WIDTH  = 4;
  localparam int CNT_W  = 16;
  localparam int ICNT_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic              o_cfg_ready;
  logic [WIDTH-1:0]  i_cfg_mask = 4'b0000;
  logic [1:0]        i_cfg_ctrl = 2'b00;
  logic [CNT_W-1:0]  i_cfg_delay = 16'd0;
  logic [CNT_W-1:0]  i_cfg_duration = 16'd0;
  logic              i_trigger = 1'b0;
  logic              i_abort = 1'b0;
  logic              o_en_super_sabouter;
  logic [WIDTH-1:0]  o_en_basic_sabouter;
  logic [1:0]        o_ctrl;
  logic              o_busy;
  logic              o_done;
  logic [ICNT_W-1:0] o_inject_cnt;

  sabouter_injection_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ICNT_W(ICNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_mask(i_cfg_mask), .i_cfg_ctrl(i_cfg_ctrl), .i_cfg_delay(i_cfg_delay),
    .i_cfg_duration(i_cfg_duration), .i_trigger(i_trigger), .i_abort(i_abort),
    .o_en_super_sabouter(o_en_super_sabouter), .o_en_basic_sabouter(o_en_basic_sabouter),
    .o_ctrl(o_ctrl), .o_busy(o_busy), .o_done(o_done), .o_inject_cnt(o_inject_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] ctrl;
    int         delay;
    int         dur;
    int         abort_t;
    bit         noise;
  } vec_t;

  typedef struct {
    logic       en;
    logic [3:0] basic;
    logic       done;
    logic       busy;
    logic       ready;
    logic [1:0] ctrl;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One campaign step: configure, trigger at edge k, then check every cycle
  // until one cycle past the return to IDLE.
  task automatic run_step(input vec_t v);
    int   term;
    int   guard;
    int   t;
    bit   aborted;
    exp_t e;
    guard = 0;
    while (!o_cfg_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("ready_wait", 32'(o_cfg_ready), 32'd1);
    i_cfg_valid    = 1'b1;
    i_cfg_mask     = v.mask;
    i_cfg_ctrl     = v.ctrl;
    i_cfg_delay    = CNT_W'(v.delay);
    i_cfg_duration = CNT_W'(v.dur);
    step();
    i_cfg_valid = 1'b0;
    chk("accept_busy", 32'(o_busy), 32'd1);
    chk("accept_ready", 32'(o_cfg_ready), 32'd0);
    chk("accept_ctrl", 32'(o_ctrl), 32'(v.ctrl));

    aborted = (v.abort_t >= 0) && ((v.dur == 0) || (v.abort_t <= v.delay + v.dur + 1));
    term    = aborted ? v.abort_t : (v.delay + v.dur + 1);
    for (int k = 0; k <= term + 1; k++) begin
      e.en    = (k >= v.delay + 1) && (k < term);
      e.basic = e.en ? v.mask : 4'b0000;
      e.done  = !aborted && (k == term);
      if (e.done) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      e.busy  = (k < term);
      e.ready = !(k < term);
      e.ctrl  = v.ctrl;
      e.cnt   = exp_cnt[7:0];
      sb_q.push_back(e);
    end

    t = 0;
    while (sb_q.size() > 0) begin
      i_trigger   = (t == 0);
      i_abort     = (t == v.abort_t);
      i_cfg_valid = v.noise && (t <= term);
      i_cfg_mask  = ~v.mask;
      i_cfg_ctrl  = ~v.ctrl;
      step();
      e = sb_q.pop_front();
      chk("en_super", 32'(o_en_super_sabouter), 32'(e.en));
      chk("en_basic", 32'(o_en_basic_sabouter), 32'(e.basic));
      chk("done", 32'(o_done), 32'(e.done));
      chk("busy", 32'(o_busy), 32'(e.busy));
      chk("cfg_ready", 32'(o_cfg_ready), 32'(e.ready));
      chk("ctrl", 32'(o_ctrl), 32'(e.ctrl));
      chk("inject_cnt", 32'(o_inject_cnt), 32'(e.cnt));
      t++;
    end
    i_trigger   = 1'b0;
    i_abort     = 1'b0;
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t sat_v;
    //                 mask     ctrl   dly dur abort noise
    vecs[0] = '{4'b1010, 2'b10, 3, 2,  -1, 1'b0};
    vecs[1] = '{4'b0111, 2'b01, 0, 1,  -1, 1'b1};
    vecs[2] = '{4'b1111, 2'b11, 0, 0,  21, 1'b0};
    vecs[3] = '{4'b0011, 2'b00, 2, 3,   6, 1'b0};
    vecs[4] = '{4'b1100, 2'b01, 5, 1,   0, 1'b0};
    vecs[5] = '{4'b0000, 2'b10, 1, 4,  -1, 1'b1};
    vecs[6] = '{4'b0101, 2'b11, 4, 2,   2, 1'b1};

    // Reset held with a configuration offered.
    i_cfg_valid    = 1'b1;
    i_cfg_mask     = 4'b1001;
    i_cfg_ctrl     = 2'b11;
    i_cfg_delay    = 16'd0;
    i_cfg_duration = 16'd5;
    #12;
    chk("rst_ready", 32'(o_cfg_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_en", 32'(o_en_super_sabouter), 32'd0);
    chk("rst_basic", 32'(o_en_basic_sabouter), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_cnt", 32'(o_inject_cnt), 32'd0);
    chk("rst_ctrl", 32'(o_ctrl), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    i_cfg_valid = 1'b0;
    chk("first_accept_busy", 32'(o_busy), 32'd1);
    chk("first_accept_ctrl", 32'(o_ctrl), 32'd3);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("armed_abort_busy", 32'(o_busy), 32'd0);
    chk("armed_abort_ready", 32'(o_cfg_ready), 32'd1);
    chk("armed_abort_done", 32'(o_done), 32'd0);

    for (int i = 0; i < 7; i++) run_step(vecs[i]);

    // Back-to-back completions to saturate the counter.
    sat_v = '{4'b0001, 2'b01, 0, 1, -1, 1'b1};
    for (int i = 0; i < 260; i++) run_step(sat_v);
    chk("sat_cnt", 32'(o_inject_cnt), 32'hFF);

    // Asynchronous reset in the middle of a permanent injection.
    run_step('{4'b1000, 2'b10, 1, 3, -1, 1'b0});
    i_cfg_valid    = 1'b1;
    i_cfg_mask     = 4'b0110;
    i_cfg_ctrl     = 2'b01;
    i_cfg_delay    = 16'd0;
    i_cfg_duration = 16'd0;
    step();
    i_cfg_valid = 1'b0;
    i_trigger   = 1'b1;
    step();
    i_trigger = 1'b0;
    step();
    step();
    chk("perm_en", 32'(o_en_super_sabouter), 32'd1);
    chk("perm_basic", 32'(o_en_basic_sabouter), 32'(4'b0110));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(o_en_super_sabouter), 32'd0);
    chk("async_rst_basic", 32'(o_en_basic_sabouter), 32'd0);
    chk("async_rst_cnt", 32'(o_inject_cnt), 32'd0);
    chk("async_rst_ready", 32'(o_cfg_ready), 32'd1);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    chk("post_rst_en", 32'(o_en_super_sabouter), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sabouter_injection_ctrl.md
Name: sabouter_injection_ctrl

Overview:
- Sequential controller directly upstream of the super saboteur.
- Accepts one fault-injection configuration per campaign step: bit mask, fault-type control, start delay, duration.
- Waits for a trigger, then drives the saboteur enable, per-bit enables and control code for exactly the programmed window.
- Reports completion and keeps a count of completed injections.

Parameters:
- WIDTH, 4, number of saboteur bits; matches the downstream super saboteur.
- CNT_W, 16, width of the delay and duration counters.
- ICNT_W, 8, width of the completed-injection counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cfg_valid  in  1  configuration offered.
- o_cfg_ready  out  1  controller can accept a configuration; high only in IDLE.
- i_cfg_mask  in  WIDTH  bits to corrupt; becomes the per-bit saboteur enable.
- i_cfg_ctrl  in  2  fault-type code, passed opaque to the saboteur i_ctrl.
- i_cfg_delay  in  CNT_W  cycles between trigger and injection start.
- i_cfg_duration  in  CNT_W  injection length in cycles; 0 means permanent until abort.
- i_trigger  in  1  start event.
- i_abort  in  1  cancel current step.
- o_en_super_sabouter  out  1  global saboteur enable.
- o_en_basic_sabouter  out  WIDTH  per-bit enables.
- o_ctrl  out  2  fault-type code.
- o_busy  out  1  high in ARMED, WAIT and INJECT.
- o_done  out  1  one-cycle pulse on normal completion.
- o_inject_cnt  out  ICNT_W  completed injections; saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs and internal registers 0, except o_cfg_ready = 1.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, ARMED, WAIT, INJECT.
- IDLE:
  - o_cfg_ready = 1.
  - On i_cfg_valid, latch mask, ctrl, delay and duration, then go to ARMED.
  - A zero mask is accepted; the injection still runs, but o_en_basic_sabouter stays 0.
  - i_trigger is ignored.
- ARMED:
  - On i_trigger with delay = 0, go to INJECT.
  - On i_trigger with delay > 0, load the counter with delay and go to WAIT.
- WAIT: decrement the counter each cycle; on the cycle the counter reaches 1, go to INJECT.
- Start timing: if the trigger is sampled at edge k, the enables are first high after edge k+1+delay.
- INJECT:
  - o_en_super_sabouter = 1; o_en_basic_sabouter = latched mask.
  - The enables stay high for exactly duration cycles, then return to IDLE.
  - On that return, o_done pulses for one cycle coincident with the enables dropping, and o_inject_cnt increments, saturating at all-ones.
  - With duration = 0 the controller stays in INJECT until i_abort.
- Outside INJECT, o_en_super_sabouter = 0 and o_en_basic_sabouter = 0.
- o_ctrl:
  - Loaded on configuration accept and held until the next accept.
  - It is therefore stable at least one cycle before the enables rise, and during and after injection.
- i_abort (ARMED/WAIT/INJECT): go to IDLE next edge, enables 0; no o_done pulse; o_inject_cnt unchanged.
- Simultaneous events:
  - Abort beats trigger in ARMED.
  - Abort beats completion on the last INJECT cycle.
  - i_trigger in WAIT or INJECT is ignored (no retrigger).
  - i_cfg_valid outside IDLE is ignored; the configuration is not latched.
- Config accepted on the same edge as the return to IDLE: not possible, because ready is registered and low during that cycle. The earliest new accept is the cycle after o_done.
- Reset mid-injection: enables drop asynchronously; counter and state clear.

Test Plan:
- Reset with i_cfg_valid=1 held -> o_cfg_ready=1 and all other outputs 0; first edge after release accepts the configuration and o_busy rises.
- Config mask=4'b1010, ctrl=2'b10, delay=3, duration=2; trigger at edge k -> enables high after edges k+4 and k+5 only, o_en_basic_sabouter=4'b1010, o_done pulse after edge k+6, o_inject_cnt=1, o_ctrl=2'b10 throughout.
- delay=0, duration=1 -> enables high for exactly one cycle starting the edge after trigger, then o_done.
- duration=0, trigger, hold 20 cycles, then abort -> enables high all 20 cycles and drop the edge after abort; no o_done; o_inject_cnt unchanged.
- Abort asserted on the final INJECT cycle, and separately abort with trigger in ARMED -> no o_done, no count change, return to IDLE, never injects in the ARMED case.
- 260 back-to-back injections with ICNT_W=8 -> o_inject_cnt saturates at 255; cfg_valid pulses during busy are ignored (o_ctrl unchanged).
